oro_change_monitor: RTL

- Multi-channel signal-change monitor for co-simulation benches.
- Watches NCH channels of W bits each. Every value change on an enabled channel becomes an event record {timestamp, channel, new value}.
- Events are buffered in a FIFO and drained over a valid/ready port by the VM bridge task.
- Replaces the ad-hoc per-signal change-display processes with a single synthesizable, lossless-or-counted event stream.

---
 rtl/oro_mon_pkg.sv | 17 +
 rtl/oro_mon_fifo.sv | 57 +++++
 rtl/oro_change_monitor.sv | 133 +++++++++++++
 3 files changed

// File: rtl/oro_mon_pkg.sv
// Shared constants and helpers for the change monitor: counter widths and
// the packed event record layout {ts, ch, data}, timestamp in the MSBs.
package oro_mon_pkg;

  localparam int OVF_W = 16;

  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int evt_rec_w(input int tsw, input int chw, input int w);
    return tsw + chw + w;
  endfunction

endpackage

// File: rtl/oro_mon_fifo.sv
// First-word-fall-through FIFO: the head entry is visible on dout whenever
// the FIFO is not empty. A push while full is accepted only alongside a pop.
module oro_mon_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    cnt_reg;
  logic             do_pop;
  logic             do_push;

  assign empty   = (cnt_reg == '0);
  assign full    = (cnt_reg == LW'(DEPTH));
  assign level   = cnt_reg;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (do_push && !do_pop)      cnt_reg <= cnt_reg + LW'(1);
      else if (do_pop && !do_push) cnt_reg <= cnt_reg - LW'(1);
    end
  end

  // Storage carries no reset so it can map onto RAM; occupancy guards its use.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/oro_change_monitor.sv
// Multi-channel change monitor: detects value changes on enabled channels,
// parks them in per-channel pending slots and streams them out via a FIFO.
module oro_change_monitor
  import oro_mon_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int W     = 32,
  parameter int DEPTH = 16,
  parameter int TSW   = 32,
  localparam int CHW  = clog2_min1(NCH),
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH*W-1:0]   ch_data,
  input  logic [NCH-1:0]     ch_en,
  input  logic               clr,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [TSW-1:0]     evt_ts,
  output logic [CHW-1:0]     evt_ch,
  output logic [W-1:0]       evt_data,
  output logic [LW-1:0]      level,
  output logic [OVF_W-1:0]   ovf_cnt
);

  localparam int RW = evt_rec_w(TSW, CHW, W);

  logic [TSW-1:0]   ts_reg;
  logic             primed_reg;
  logic [W-1:0]     prev_reg     [NCH];
  logic [NCH-1:0]   pend_reg;
  logic [TSW-1:0]   slot_ts_reg  [NCH];
  logic [W-1:0]     slot_val_reg [NCH];
  logic [OVF_W-1:0] ovf_reg;

  logic [NCH-1:0]   chg;
  logic [NCH-1:0]   ovf_hit;
  logic [NCH-1:0]   pushing;
  logic [CHW-1:0]   sel;
  logic             push_en;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [RW-1:0]    fifo_din;
  logic [RW-1:0]    fifo_dout;
  logic [4:0]       ovf_inc;
  logic [OVF_W:0]   ovf_sum;
  logic [OVF_W-1:0] ovf_next;

  // A slot being pushed this edge frees up, so a same-edge change refills it
  // instead of counting as a coalesced overwrite.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      assign chg[gi]     = primed_reg & ch_en[gi] & (ch_data[gi*W +: W] != prev_reg[gi]);
      assign ovf_hit[gi] = chg[gi] & pend_reg[gi] & ~pushing[gi];
    end
  endgenerate

  always_comb begin
    sel = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pend_reg[i]) sel = CHW'(i);
    end
  end

  assign pop      = ~fifo_empty & evt_ready;
  assign push_en  = (|pend_reg) & (~fifo_full | pop);
  assign pushing  = push_en ? (NCH'(1) << sel) : '0;
  assign fifo_din = {slot_ts_reg[sel], sel, slot_val_reg[sel]};

  always_comb begin
    ovf_inc = '0;
    for (int i = 0; i < NCH; i++) ovf_inc = ovf_inc + 5'(ovf_hit[i]);
    ovf_sum  = {1'b0, ovf_reg} + (OVF_W + 1)'(ovf_inc);
    ovf_next = ovf_sum[OVF_W] ? {OVF_W{1'b1}} : ovf_sum[OVF_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_reg     <= '0;
      primed_reg <= 1'b0;
      ovf_reg    <= '0;
      pend_reg   <= '0;
      for (int i = 0; i < NCH; i++) begin
        prev_reg[i]     <= '0;
        slot_ts_reg[i]  <= '0;
        slot_val_reg[i] <= '0;
      end
    end else if (clr) begin
      ts_reg     <= '0;
      primed_reg <= 1'b0;
      ovf_reg    <= '0;
      pend_reg   <= '0;
    end else begin
      ts_reg     <= ts_reg + TSW'(1);
      primed_reg <= 1'b1;
      ovf_reg    <= ovf_next;
      for (int i = 0; i < NCH; i++) begin
        prev_reg[i] <= ch_data[i*W +: W];
        if (chg[i]) begin
          pend_reg[i]     <= 1'b1;
          slot_ts_reg[i]  <= ts_reg;
          slot_val_reg[i] <= ch_data[i*W +: W];
        end else if (pushing[i]) begin
          pend_reg[i] <= 1'b0;
        end
      end
    end
  end

  oro_mon_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push_en),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (level)
  );

  assign evt_valid = ~fifo_empty;
  assign {evt_ts, evt_ch, evt_data} = fifo_empty ? {RW{1'b0}} : fifo_dout;
  assign ovf_cnt = ovf_reg;

endmodule
